// File: rtl/bcd_entry_pkg.sv
// Shared definitions for the BCD keypad entry block and the converter control:
// state encoding, digit geometry and the legal-digit check.
package bcd_entry_pkg;

  // Controller states, 2-bit encoding shared with the converter control
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LAUNCH  = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  // Digit geometry: five BCD digits feed the 20-bit converter input
  localparam int MAX_DIGITS = 5;
  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGIT  = 9;
  localparam int BCD_W      = MAX_DIGITS * DIGIT_W;
  localparam int NDIG_W     = 3;

  // A digit is legal when it is a decimal value 0..9
  function automatic logic is_legal_digit(input logic [DIGIT_W-1:0] d);
    return (d <= DIGIT_W'(MAX_DIGIT));
  endfunction

endpackage

// File: rtl/bcd_entry_timer.sv
// Conversion watchdog: cleared by start, counts while run is high and flags
// expiry when the count reaches TIMEOUT-1.
module bcd_entry_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_r;

  // Cycle counter: zeroed on start, advances each cycle while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (start) begin
      cnt_r <= '0;
    end else if (run) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry is derived from the registered count and the state-decoded run
  assign expired = run && (cnt_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bcd_entry.sv
// BCD keypad entry: collects up to MAX_DIGITS decimal digits into a
// right-justified shift register, launches a conversion on enter and waits
// for the converter (with a watchdog) before accepting new input.
module bcd_entry #(
  parameter int MAX_DIGITS = bcd_entry_pkg::MAX_DIGITS,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        enter,
  input  logic        clear,
  input  logic        conv_done,
  output logic        conv_init,
  output logic [19:0] bcd_out,
  output logic [2:0]  ndigits,
  output logic        busy,
  output logic        err
);

  import bcd_entry_pkg::*;

  state_t            state_r;
  logic [BCD_W-1:0]  bcd_r;
  logic [NDIG_W-1:0] ndigits_r;
  logic              conv_init_r;
  logic              busy_r;
  logic              err_r;
  logic              timer_start_s;
  logic              timer_run_s;
  logic              timer_expired_s;
  logic              digit_ok_s;

  assign digit_ok_s    = is_legal_digit(digit);
  assign timer_start_s = (state_r == ST_LAUNCH);
  assign timer_run_s   = (state_r == ST_WAIT);

  bcd_entry_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start_s),
    .run     (timer_run_s),
    .expired (timer_expired_s)
  );

  // Controller FSM with the digit shift register, count and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      bcd_r       <= '0;
      ndigits_r   <= '0;
      conv_init_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      conv_init_r <= 1'b0;
      err_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (clear) begin
            bcd_r     <= '0;
            ndigits_r <= '0;
          end else if (enter) begin
            // Nothing to convert; ignored silently
            state_r <= ST_IDLE;
          end else if (digit_valid) begin
            if (digit_ok_s) begin
              bcd_r     <= {{(BCD_W-DIGIT_W){1'b0}}, digit};
              ndigits_r <= NDIG_W'(1);
              state_r   <= ST_COLLECT;
            end else begin
              err_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (clear) begin
            bcd_r     <= '0;
            ndigits_r <= '0;
            state_r   <= ST_IDLE;
          end else if (enter) begin
            conv_init_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_LAUNCH;
          end else if (digit_valid) begin
            if (!digit_ok_s || (ndigits_r == NDIG_W'(MAX_DIGITS))) begin
              // Illegal digit or register full: drop it and flag
              err_r <= 1'b1;
            end else begin
              bcd_r     <= {bcd_r[BCD_W-DIGIT_W-1:0], digit};
              ndigits_r <= ndigits_r + NDIG_W'(1);
            end
          end else begin
            state_r <= ST_COLLECT;
          end
        end
        ST_LAUNCH: begin
          // Start pulse lasts exactly this one cycle
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (conv_done) begin
            // Completion wins over a coincident timeout
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (timer_expired_s) begin
            busy_r  <= 1'b0;
            err_r   <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          bcd_r       <= '0;
          ndigits_r   <= '0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign conv_init = conv_init_r;
  assign bcd_out   = bcd_r;
  assign ndigits   = ndigits_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_bcd_entry.sv
// Directed self-checking bench for bcd_entry (TIMEOUT overridden to 8).
module tb_bcd_entry;

  logic        clk;
  logic        rst;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        enter;
  logic        clear;
  logic        conv_done;
  logic        conv_init;
  logic [19:0] bcd_out;
  logic [2:0]  ndigits;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_entry #(
    .MAX_DIGITS (5),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .enter       (enter),
    .clear       (clear),
    .conv_done   (conv_done),
    .conv_init   (conv_init),
    .bcd_out     (bcd_out),
    .ndigits     (ndigits),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [19:0] b, input logic [2:0] n,
                         input logic ci, input logic bz, input logic e);
    chk({tag, ".bcd"}, bcd_out, b);
    chk({tag, ".nd"}, 20'(ndigits), 20'(n));
    chk({tag, ".init"}, 20'(conv_init), 20'(ci));
    chk({tag, ".busy"}, 20'(busy), 20'(bz));
    chk({tag, ".err"}, 20'(err), 20'(e));
  endtask

  initial begin
    rst = 1'b1; digit_valid = 1'b0; digit = 4'h0;
    enter = 1'b0; clear = 1'b0; conv_done = 1'b0;
    tick(); tick();
    chk_all("reset", 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // 1,2,3 then enter
    put_digit(4'd1); put_digit(4'd2); put_digit(4'd3);
    chk_all("d123", 20'h00123, 3'd3, 1'b0, 1'b0, 1'b0);
    enter = 1'b1; tick(); enter = 1'b0;
    chk_all("launch", 20'h00123, 3'd3, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("wait1", 20'h00123, 3'd3, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("wait2", 20'h00123, 3'd3, 1'b0, 1'b1, 1'b0);
    conv_done = 1'b1; tick(); conv_done = 1'b0;
    chk_all("done", 20'h00123, 3'd3, 1'b0, 1'b0, 1'b0);

    // 9,8,7,6,5,4: sixth digit dropped with err
    clear = 1'b1; tick(); clear = 1'b0;
    chk_all("clr1", 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0);
    put_digit(4'd9); put_digit(4'd8); put_digit(4'd7); put_digit(4'd6); put_digit(4'd5);
    chk_all("full", 20'h98765, 3'd5, 1'b0, 1'b0, 1'b0);
    put_digit(4'd4);
    chk_all("over", 20'h98765, 3'd5, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("over_end", 20'h98765, 3'd5, 1'b0, 1'b0, 1'b0);

    // illegal digits in IDLE and COLLECT
    clear = 1'b1; tick(); clear = 1'b0;
    put_digit(4'hA);
    chk_all("badA", 20'h00000, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("badA_end.err", 20'(err), 20'd0);
    put_digit(4'd1);
    chk_all("one", 20'h00001, 3'd1, 1'b0, 1'b0, 1'b0);
    put_digit(4'hC);
    chk_all("badC", 20'h00001, 3'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("badC_end.err", 20'(err), 20'd0);

    // 4,2 then clear+enter+digit in one cycle
    clear = 1'b1; tick(); clear = 1'b0;
    put_digit(4'd4); put_digit(4'd2);
    chk_all("d42", 20'h00042, 3'd2, 1'b0, 1'b0, 1'b0);
    clear = 1'b1; enter = 1'b1; digit_valid = 1'b1; digit = 4'd7;
    tick();
    clear = 1'b0; enter = 1'b0; digit_valid = 1'b0;
    chk_all("prio", 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("prio2", 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0);

    // timeout: err exactly 8 cycles after entering WAIT
    put_digit(4'd5);
    enter = 1'b1; tick(); enter = 1'b0;
    chk("to_launch.init", 20'(conv_init), 20'd1);
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("to_wait%0d.err", i), 20'(err), 20'd0);
      chk($sformatf("to_wait%0d.busy", i), 20'(busy), 20'd1);
    end
    tick();
    chk_all("timeout", 20'h00005, 3'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("timeout_end", 20'h00005, 3'd1, 1'b0, 1'b0, 1'b0);

    // reset two cycles into WAIT, then a stray conv_done
    put_digit(4'd3);
    enter = 1'b1; tick(); enter = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst.busy", 20'(busy), 20'd1);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    conv_done = 1'b1; tick(); conv_done = 1'b0;
    chk_all("post_rst", 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("quiet%0d.err", i), 20'(err), 20'd0);
    end
    // a fresh digit still loads normally after the abandoned conversion
    put_digit(4'd8);
    chk_all("after", 20'h00008, 3'd1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_entry.md
BCD_ENTRY -- requirements
Module: bcd_entry

Interface
REQ-001 Parameter: MAX_DIGITS, 5, maximum BCD digits held; fixed to match the 20-bit BCD input of the downstream BCD-to-binary converter.
REQ-002 Parameter: TIMEOUT, 255, maximum cycles spent in WAIT for conv_done.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 digit_valid  input  1  one-cycle strobe qualifying digit.
REQ-006 digit  input  4  BCD digit to append; legal values 0..9.
REQ-007 enter  input  1  one-cycle strobe requesting conversion of the held digits.
REQ-008 clear  input  1  one-cycle strobe discarding the held digits.
REQ-009 conv_done  input  1  one-cycle completion pulse from the converter.
REQ-010 conv_init  output  1  one-cycle start pulse to the converter.
REQ-011 bcd_out  output  20  held digits, most recent digit in bits [3:0], packed right-justified.
REQ-012 ndigits  output  3  count of held digits, 0..5.
REQ-013 busy  output  1  high in LAUNCH and WAIT.
REQ-014 err  output  1  one-cycle pulse on any rejected input or timeout.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, LAUNCH and WAIT.
REQ-016 In IDLE, a legal digit SHALL load bcd_out={16'h0,digit}, set ndigits=1 and move to COLLECT on the next edge.
REQ-017 In COLLECT with ndigits<5, a legal digit SHALL shift in: bcd_out<={bcd_out[15:0],digit}, ndigits+1.
REQ-018 In COLLECT with ndigits==5, a digit SHALL be dropped, with bcd_out unchanged and err pulsed for one cycle.
REQ-019 In IDLE or COLLECT, a digit >9 SHALL be dropped and err pulsed for one cycle; state and count are unchanged.
REQ-020 Priority within one cycle SHALL be clear > enter > digit_valid; a digit coincident with a taken clear or enter is dropped with no err.
REQ-021 clear in COLLECT SHALL return to IDLE with bcd_out=0 and ndigits=0; clear in IDLE SHALL have no effect apart from holding zeros.
REQ-022 enter in COLLECT SHALL move to LAUNCH; enter in IDLE SHALL be ignored without err.
REQ-023 LAUNCH SHALL last exactly one cycle, assert conv_init=1 for that cycle, then go to WAIT.
REQ-024 bcd_out and ndigits SHALL be held stable from LAUNCH until WAIT exits.
REQ-025 In WAIT, conv_done=1 SHALL return to IDLE on the next edge, retaining bcd_out/ndigits until the next digit or clear.
REQ-026 In WAIT, a cycle counter SHALL start at 0 on entry and increment each cycle; reaching TIMEOUT-1 without conv_done SHALL pulse err and return to IDLE.
REQ-027 If conv_done and timeout coincide, conv_done SHALL win and no err is asserted.
REQ-028 In LAUNCH and WAIT, digit_valid, enter and clear SHALL be ignored without err.
REQ-029 A conv_done received outside WAIT SHALL be ignored.
REQ-030 The outputs conv_init, busy and err SHALL be registered or decoded from state only, with no combinational path from any input.

Reset
REQ-031 On rst the block SHALL enter IDLE immediately, with bcd_out=0, ndigits=0, conv_init=0, busy=0, err=0 and the timeout counter at 0.
REQ-032 rst asserted mid-WAIT SHALL abandon the conversion, and no err pulse SHALL follow reset release.

Structure
REQ-033 The state encodings (2-bit), MAX_DIGITS, the BCD digit width (4) and the maximum legal digit (9) SHALL reside in a shared package used by bcd_entry and the converter control.
REQ-034 The timeout counter SHALL be one sub-module, bcd_entry_timer, with ports clk, rst, start, run and expired.
REQ-035 The datapath (shift register and counter) and the FSM SHALL stay in bcd_entry.

Verification
REQ-036 Stimulus: digits 1,2,3 then enter. Required: bcd_out=20'h00123, ndigits=3, conv_init high exactly one cycle, busy high until conv_done.
REQ-037 Stimulus: digits 9,8,7,6,5,4. Required: bcd_out=20'h98765, a single err pulse on the sixth digit, ndigits=5.
REQ-038 Stimulus: digit 4'hA in IDLE, then digit 4'hC in COLLECT. Required: err pulses on both, and bcd_out/ndigits unchanged.
REQ-039 Stimulus: digits 4,2 followed by same-cycle clear+enter+digit 7. Required: IDLE, bcd_out=0, ndigits=0, no conv_init, no err.
REQ-040 Stimulus: enter with conv_done never returned and TIMEOUT=8. Required: err pulse 8 cycles after WAIT entry, then IDLE with bcd_out retained.
REQ-041 Stimulus: rst pulse two cycles into WAIT, then conv_done. Required: IDLE with all outputs zero, conv_done ignored, no err.
